// File: rtl/column_packer.sv
// rtl/column_packer.sv - packs narrow column elements LSB-first into wide FIFO words with valid/last handshake
// Optional: COLUMN_PACKER_STALL_COUNT_EN adds stall_count_out (cycles spent holding a word under backpressure).
module column_packer #(
  parameter int ELEM_WIDTH      = 16,
  parameter int DATA_WIDTH      = 256,
  parameter int ELEMS_PER_FRAME = 2304
) (
  input  logic                  clk_pixel,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  input  logic                  col_valid_in,
  input  logic [ELEM_WIDTH-1:0] col_data_in,
  output logic                  col_ready_out,
  input  logic                  fifo_ready_in,
  output logic                  packed_valid_out,
  output logic [DATA_WIDTH-1:0] packed_data_out,
  output logic                  packed_last_out
`ifdef COLUMN_PACKER_STALL_COUNT_EN
  ,output logic [15:0]          stall_count_out
`endif
);

  // DATA_WIDTH is expected to be an integer multiple of ELEM_WIDTH.
  localparam int EPW    = DATA_WIDTH / ELEM_WIDTH;
  localparam int SLOT_W = $clog2(EPW + 1);
  localparam int CNT_W  = $clog2(ELEMS_PER_FRAME + 1);

  localparam logic [SLOT_W-1:0] SLOTS_PER_WORD = SLOT_W'(EPW);
  localparam logic [CNT_W-1:0]  FRAME_LEN      = CNT_W'(ELEMS_PER_FRAME);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]            r_state;
  logic [SLOT_W-1:0]     r_slot_cnt;
  logic [CNT_W-1:0]      r_elem_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  logic [DATA_WIDTH-1:0] w_next_word;
  logic [SLOT_W-1:0]     w_slot_inc;
  logic [CNT_W-1:0]      w_elem_inc;
  logic                  w_frame_done;
  logic                  w_word_done;

  assign w_slot_inc   = r_slot_cnt + 1'b1;
  assign w_elem_inc   = r_elem_cnt + 1'b1;
  assign w_frame_done = (w_elem_inc == FRAME_LEN);
  assign w_word_done  = (w_slot_inc == SLOTS_PER_WORD) || w_frame_done;

  // The shift register is zeroed after every word, so unfilled slots of a short final word read as zero.
  always_comb begin
    w_next_word = r_shift;
    for (int s = 0; s < EPW; s++) begin
      if (r_slot_cnt == SLOT_W'(s)) begin
        w_next_word[s*ELEM_WIDTH +: ELEM_WIDTH] = col_data_in;
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= ST_FILL;
      r_slot_cnt <= '0;
      r_elem_cnt <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_last     <= 1'b0;
    end else if (frame_start_in) begin
      r_state    <= ST_FILL;
      r_slot_cnt <= '0;
      r_elem_cnt <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (col_valid_in) begin
            r_elem_cnt <= w_elem_inc;
            if (w_word_done) begin
              r_data     <= w_next_word;
              r_last     <= w_frame_done;
              r_slot_cnt <= '0;
              r_shift    <= '0;
              r_state    <= ST_HOLD;
            end else begin
              r_shift    <= w_next_word;
              r_slot_cnt <= w_slot_inc;
            end
          end
        end
        default: begin
          if (fifo_ready_in) begin
            r_state <= ST_FILL;
            if (r_last) begin
              r_elem_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

  assign col_ready_out    = (r_state == ST_FILL);
  assign packed_valid_out = (r_state == ST_HOLD);
  assign packed_data_out  = r_data;
  assign packed_last_out  = r_last;

`ifdef COLUMN_PACKER_STALL_COUNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_pixel or posedge rst_in) begin
    if (rst_in) begin
      r_stall_cnt <= '0;
    end else if (frame_start_in) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_HOLD) && !fifo_ready_in && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count_out = r_stall_cnt;
`endif

endmodule

// File: tb/tb_column_packer.sv
// tb/tb_column_packer.sv - directed self-checking bench for column_packer
// Exercises a 40-element frame instance and a default-parameter instance.
module tb_column_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small-frame instance (ELEMS_PER_FRAME = 40)
  logic         frame_start = 1'b0;
  logic         col_valid   = 1'b0;
  logic [15:0]  col_data    = '0;
  logic         fifo_ready  = 1'b1;
  logic         ready;
  logic         valid;
  logic [255:0] data;
  logic         last;

  // Default-parameter instance
  logic         d_frame_start = 1'b0;
  logic         d_col_valid   = 1'b0;
  logic [15:0]  d_col_data    = '0;
  logic         d_fifo_ready  = 1'b0;
  logic         d_ready;
  logic         d_valid;
  logic [255:0] d_data;
  logic         d_last;

`ifdef COLUMN_PACKER_STALL_COUNT_EN
  logic [15:0] stall;
  logic [15:0] d_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  column_packer #(.ELEM_WIDTH(16), .DATA_WIDTH(256), .ELEMS_PER_FRAME(40)) dut (
    .clk_pixel        (clk),
    .rst_in           (rst),
    .frame_start_in   (frame_start),
    .col_valid_in     (col_valid),
    .col_data_in      (col_data),
    .col_ready_out    (ready),
    .fifo_ready_in    (fifo_ready),
    .packed_valid_out (valid),
    .packed_data_out  (data),
    .packed_last_out  (last)
`ifdef COLUMN_PACKER_STALL_COUNT_EN
    ,.stall_count_out (stall)
`endif
  );

  column_packer dut_def (
    .clk_pixel        (clk),
    .rst_in           (rst),
    .frame_start_in   (d_frame_start),
    .col_valid_in     (d_col_valid),
    .col_data_in      (d_col_data),
    .col_ready_out    (d_ready),
    .fifo_ready_in    (d_fifo_ready),
    .packed_valid_out (d_valid),
    .packed_data_out  (d_data),
    .packed_last_out  (d_last)
`ifdef COLUMN_PACKER_STALL_COUNT_EN
    ,.stall_count_out (d_stall)
`endif
  );

  function automatic logic [255:0] build_word(input logic [15:0] base, input int n);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[i*16 +: 16] = base + 16'(i);
    return w;
  endfunction

  function automatic logic [15:0] def_elem(input int idx);
    return 16'((idx * 37 + 11) & 16'hFFFF);
  endfunction

  // Offers n consecutive elements back to back; ends #1 after the last accept edge.
  task automatic feed(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      col_valid = 1'b1;
      col_data  = base + 16'(i);
      @(posedge clk); #1;
    end
    col_valid = 1'b0;
  endtask

  task automatic xfer();
    fifo_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_checks++; if (data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data); end
    n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", last); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_def_valid got=%b exp=0", d_valid); end
`ifdef COLUMN_PACKER_STALL_COUNT_EN
    n_checks++; if (stall !== 16'd0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall); end
`endif
  endtask

  task automatic test_full_word();
    fifo_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      col_valid = 1'b1;
      col_data  = 16'(i + 1);
      @(posedge clk); #1;
    end
    col_data = 16'h0011;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got=%b exp=1", valid); end
    n_checks++; if (data[15:0] !== 16'h0001) begin n_fail++; $display("FAIL full_slot0 got=%h exp=0001", data[15:0]); end
    n_checks++; if (data[255:240] !== 16'h0010) begin n_fail++; $display("FAIL full_slot15 got=%h exp=0010", data[255:240]); end
    n_checks++; if (data !== build_word(16'h0001, 16)) begin n_fail++; $display("FAIL full_word got=%h exp=%h", data, build_word(16'h0001, 16)); end
    n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL full_last got=%b exp=0", last); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_hold got=%b exp=0", ready); end
    col_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back got=%b exp=1", ready); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_drop got=%b exp=0", valid); end
  endtask

  task automatic test_partial_word();
    feed(16'h0011, 16);
    n_checks++; if (data !== build_word(16'h0011, 16) || last !== 1'b0) begin n_fail++; $display("FAIL word2 got=%h/%b exp=%h/0", data, last, build_word(16'h0011, 16)); end
    xfer();
    feed(16'h0021, 8);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL partial_valid got=%b exp=1", valid); end
    n_checks++; if (data !== build_word(16'h0021, 8)) begin n_fail++; $display("FAIL partial_data got=%h exp=%h", data, build_word(16'h0021, 8)); end
    n_checks++; if (data[255:128] !== '0) begin n_fail++; $display("FAIL partial_pad got=%h exp=0", data[255:128]); end
    n_checks++; if (last !== 1'b1) begin n_fail++; $display("FAIL partial_last got=%b exp=1", last); end
    xfer();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL partial_xfer got=%b exp=0", valid); end
  endtask

  task automatic test_backpressure();
    logic [255:0] exp_w;
    fifo_ready = 1'b0;
    feed(16'h0101, 16);
    exp_w = build_word(16'h0101, 16);
    col_valid = 1'b1;
    col_data  = 16'h0BAD;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if (valid !== 1'b1 || data !== exp_w || ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_%0d got=%b/%h/%b exp=1/%h/0", c, valid, data, ready, exp_w); end
    end
`ifdef COLUMN_PACKER_STALL_COUNT_EN
    n_checks++; if (stall !== 16'd5) begin n_fail++; $display("FAIL bp_stall got=%0d exp=5", stall); end
`endif
    col_valid = 1'b0;
    xfer();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_xfer got=%b exp=0", valid); end
    // Rest of this frame; last on word 3 proves the frame count restarted after the previous last.
    feed(16'h0111, 16);
    n_checks++; if (data !== build_word(16'h0111, 16) || last !== 1'b0) begin n_fail++; $display("FAIL bp_word2 got=%h/%b exp=%h/0", data, last, build_word(16'h0111, 16)); end
    xfer();
    feed(16'h0121, 8);
    n_checks++; if (data !== build_word(16'h0121, 8) || last !== 1'b1) begin n_fail++; $display("FAIL bp_word3 got=%h/%b exp=%h/1", data, last, build_word(16'h0121, 8)); end
    xfer();
  endtask

  task automatic test_frame_start();
    fifo_ready = 1'b1;
    feed(16'h0301, 7);
    frame_start = 1'b1;
    col_valid   = 1'b1;
    col_data    = 16'hDEAD;
    @(posedge clk); #1;
    frame_start = 1'b0;
    col_valid   = 1'b0;
    n_checks++; if (valid !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL fs_state got=%b/%b exp=0/1", valid, ready); end
`ifdef COLUMN_PACKER_STALL_COUNT_EN
    n_checks++; if (stall !== 16'd0) begin n_fail++; $display("FAIL fs_stall got=%0d exp=0", stall); end
`endif
    feed(16'h0401, 16);
    n_checks++; if (data !== build_word(16'h0401, 16) || last !== 1'b0) begin n_fail++; $display("FAIL fs_word1 got=%h/%b exp=%h/0", data, last, build_word(16'h0401, 16)); end
    xfer();
    feed(16'h0411, 16);
    xfer();
    feed(16'h0421, 8);
    n_checks++; if (data !== build_word(16'h0421, 8) || last !== 1'b1) begin n_fail++; $display("FAIL fs_word3 got=%h/%b exp=%h/1", data, last, build_word(16'h0421, 8)); end
    xfer();
  endtask

  task automatic test_async_reset();
    fifo_ready = 1'b0;
    feed(16'h0501, 16);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid got=%b exp=1", valid); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got=%b exp=0", valid); end
    n_checks++; if (data !== '0) begin n_fail++; $display("FAIL ar_data got=%h exp=0", data); end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready got=%b exp=1", ready); end
    fifo_ready = 1'b1;
    feed(16'h0601, 16);
    n_checks++; if (data !== build_word(16'h0601, 16) || last !== 1'b0) begin n_fail++; $display("FAIL ar_word got=%h/%b exp=%h/0", data, last, build_word(16'h0601, 16)); end
    xfer();
  endtask

  task automatic test_default_frame();
    int idx = 0;
    int words = 0;
    int lasts = 0;
    int cycles = 0;
    logic acc;
    logic xf;
    logic [255:0] exp_w;
    while (words < 144 && cycles < 20000) begin
      d_fifo_ready = 1'($urandom_range(0, 1));
      d_col_valid  = (idx < 2304);
      d_col_data   = def_elem(idx);
      acc = d_col_valid && d_ready;
      xf  = d_valid && d_fifo_ready;
      if (xf) begin
        exp_w = '0;
        for (int s = 0; s < 16; s++) exp_w[s*16 +: 16] = def_elem(words * 16 + s);
        n_checks++; if (d_data !== exp_w) begin n_fail++; $display("FAIL def_data_w%0d got=%h exp=%h", words, d_data, exp_w); end
        n_checks++; if (d_last !== (words == 143)) begin n_fail++; $display("FAIL def_last_w%0d got=%b exp=%b", words, d_last, (words == 143)); end
        if (d_last) lasts++;
        words++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cycles++;
    end
    d_col_valid  = 1'b0;
    d_fifo_ready = 1'b1;
    n_checks++; if (words !== 144) begin n_fail++; $display("FAIL def_words got=%0d exp=144 (cycles=%0d)", words, cycles); end
    n_checks++; if (lasts !== 1) begin n_fail++; $display("FAIL def_lasts got=%0d exp=1", lasts); end
    n_checks++; if (idx !== 2304) begin n_fail++; $display("FAIL def_elems got=%0d exp=2304", idx); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL def_idle got=%b exp=0", d_valid); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_word();
    test_backpressure();
    test_frame_start();
    test_async_reset();
    test_default_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/column_packer.md
Name: column_packer

Overview:
- Upstream feeder of the column/pixel FIFO stage in the raycaster pipeline.
- Accepts narrow per-column elements one at a time from the raycast engine.
- Packs them LSB-first into DATA_WIDTH-bit words and presents each word with a valid/last handshake to the FIFO's sender-side inputs.
- Marks the final word of each frame with last and zero-pads any partial final word.

Parameters:
- ELEM_WIDTH, 16, width of one input element; DATA_WIDTH must be an integer multiple of it.
- DATA_WIDTH, 256, packed output word width; matches the FIFO data width.
- ELEMS_PER_FRAME, 2304, elements per frame; 144 full words at the defaults.

Ports:
- clk_pixel  input  1  pixel clock; the only clock.
- rst_in  input  1  asynchronous, active-high reset.
- frame_start_in  input  1  one-cycle pulse; discards any partial word and restarts the frame count.
- col_valid_in  input  1  input element valid.
- col_data_in  input  ELEM_WIDTH  input element.
- col_ready_out  output  1  packer can accept an element this cycle.
- fifo_ready_in  input  1  downstream FIFO accepts a word this cycle.
- packed_valid_out  output  1  packed word valid.
- packed_data_out  output  DATA_WIDTH  packed word.
- packed_last_out  output  1  word is the final word of the frame.

Behaviour:
- Definitions: EPW = DATA_WIDTH/ELEM_WIDTH. slot_cnt is clog2(EPW+1) bits. elem_cnt is clog2(ELEMS_PER_FRAME+1) bits.
- Reset (async, on rst_in high):
  - state=FILL, slot_cnt=0, elem_cnt=0, shift register cleared.
  - packed_valid_out=0, packed_data_out=0, packed_last_out=0, col_ready_out=1 once reset deasserts.
- States:
  - FILL: col_ready_out=1, packed_valid_out=0.
  - HOLD: col_ready_out=0, packed_valid_out=1.
- FILL accept (col_valid_in & col_ready_out):
  - Element written into slot slot_cnt, bits [slot*ELEM_WIDTH +: ELEM_WIDTH]; first element lands at LSBs.
  - slot_cnt and elem_cnt increment.
- FILL to HOLD transition, on the accept that makes either condition true:
  - slot_cnt reaches EPW.
  - elem_cnt reaches ELEMS_PER_FRAME.
- Word registration on that transition:
  - Word registered into packed_data_out, with unfilled slots zero.
  - packed_last_out=1 iff elem_cnt reached ELEMS_PER_FRAME.
  - slot_cnt cleared.
- HOLD:
  - packed_data_out and packed_last_out stay stable while fifo_ready_in=0.
  - On fifo_ready_in=1: transfer completes, go to FILL next cycle, packed_valid_out drops.
  - If the transferred word had last, elem_cnt resets to 0.
- Latency and throughput:
  - Word valid on the cycle after the accept of its final element.
  - Minimum EPW+1 cycles per word (one bubble for the HOLD handshake).
- Validity rule: packed_valid_out never deasserts without a transfer, except on reset or frame_start_in.
- frame_start_in, any state:
  - Next state FILL, slot_cnt=0, elem_cnt=0, shift register cleared, packed_valid_out=0. A pending HOLD word is dropped.
  - Priority over a simultaneous col_valid_in accept, and the element is discarded.
- Overrun: elements offered after the last word is formed are not accepted until the HOLD transfer completes, because col_ready_out=0 in HOLD.
- Reset mid-word or mid-HOLD returns to the reset values above immediately (asynchronous).

Optional Feature:
- Macro: COLUMN_PACKER_STALL_COUNT_EN.
- Defined:
  - Adds output port stall_count_out, 16 bits.
  - Counts cycles with state=HOLD and fifo_ready_in=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst_in and by frame_start_in.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Full word: ELEMS_PER_FRAME=40, feed elements 0x0001..0x0010 back-to-back with fifo_ready_in=1 -> packed_valid_out high the cycle after the 16th accept; packed_data_out[15:0]=0x0001, [255:240]=0x0010; packed_last_out=0; col_ready_out=0 for exactly 1 cycle.
- Partial last word: continue with elements 0x0011..0x0028 -> third word has slots 0..7 = 0x0021..0x0028, slots 8..15 = 0, packed_last_out=1; elem_cnt back to 0 after transfer.
- Backpressure: hold fifo_ready_in=0 for 5 cycles with a word in HOLD, col_valid_in=1 throughout -> packed_data_out stable, col_ready_out=0, no elements consumed; with the macro defined, stall_count_out=5.
- frame_start_in mid-word: accept 7 elements, then pulse frame_start_in together with col_valid_in=1 -> that element dropped; the next 16 accepts form a word starting at slot 0; frame count restarted.
- Async reset in HOLD: assert rst_in between clock edges -> packed_valid_out=0 and packed_data_out=0 before the next edge; after release the next frame packs correctly from slot 0.
- Default parameters: stream 2304 elements with random fifo_ready_in -> exactly 144 words, last only on word 144; data matches the scoreboard.
